piso_tx: RTL and testbench

Parallel-in, serial-out framed transmitter: accepts a WIDTH-bit parallel word through a valid/ready handshake and shifts it out on a single line. The frame is one start bit (0), WIDTH data bits and one stop bit (1), and each bit is held for CLKS_PER_BIT clocks. It is the serial-link transmit end for the team's parallel register blocks: a parallel register output feeds `pi`, and `so` drives the serial line.

---
 rtl/piso_tx_if.sv | 30 +++
 rtl/piso_tx.sv | 144 ++++++++++++++
 tb/tb_piso_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/piso_tx_if.sv
// Parallel-load handshake plus serial line outputs of the framed transmitter.
// The producer side drives the word; the transmitter side answers with ready/line/status.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] pi;
  logic             load_valid;
  logic             load_ready;
  logic             so;
  logic             busy;
  logic             done;

  modport master (
    output pi,
    output load_valid,
    input  load_ready,
    input  so,
    input  busy,
    input  done
  );

  modport slave (
    input  pi,
    input  load_valid,
    output load_ready,
    output so,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in, serial-out framed transmitter: start bit (0), WIDTH data bits, stop bit (1),
// each bit held CLKS_PER_BIT clocks. Word accepted through a valid/ready handshake in IDLE.
module piso_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  piso_tx_if.slave bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic              so_q, so_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              bit_end;
  logic [WIDTH-1:0]  shreg_next_bit;
  logic              first_bit;
  logic              shifted_bit;

  assign bit_end = (baud_cnt_q == BAUD_LAST);

  // Register after one bit period, and the bit that reaches the line from it.
  assign shreg_next_bit = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
  assign first_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shifted_bit    = MSB_FIRST ? shreg_next_bit[WIDTH-1] : shreg_next_bit[0];

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      so_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      so_q       <= so_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    so_d       = so_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        so_d       = 1'b1;
        busy_d     = 1'b0;
        bit_cnt_d  = '0;
        baud_cnt_d = '0;
        if (bus.load_valid) begin
          shreg_d = bus.pi;
          state_d = START;
          so_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          so_d       = first_bit;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shreg_d    = shreg_next_bit;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = STOP;
            bit_cnt_d = '0;
            so_d      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            so_d      = shifted_bit;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      STOP: begin
        so_d = 1'b1;
        if (bit_end) begin
          state_d    = IDLE;
          baud_cnt_d = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready follows state directly so a word can be taken in the cycle a frame completes.
  assign bus.load_ready = (state_q == IDLE);
  assign bus.so         = so_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: LSB-first, MSB-first and stretched-baud instances
// sharing one clock and reset, each line checked bit by bit against hand-built frames.
module tb_piso_tx;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  piso_tx_if #(.WIDTH(4)) a_if ();
  piso_tx_if #(.WIDTH(4)) b_if ();
  piso_tx_if #(.WIDTH(4)) c_if ();

  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(3), .MSB_FIRST(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(c_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // {load_ready, so, busy, done} of the selected instance.
  function automatic logic [3:0] obs(input int d);
    case (d)
      0:       obs = {a_if.load_ready, a_if.so, a_if.busy, a_if.done};
      1:       obs = {b_if.load_ready, b_if.so, b_if.busy, b_if.done};
      default: obs = {c_if.load_ready, c_if.so, c_if.busy, c_if.done};
    endcase
  endfunction

  task automatic drive(input int d, input logic [3:0] w, input logic v);
    case (d)
      0:       begin a_if.pi = w; a_if.load_valid = v; end
      1:       begin b_if.pi = w; b_if.load_valid = v; end
      default: begin c_if.pi = w; c_if.load_valid = v; end
    endcase
  endtask

  // Present a word, return #1 after the accepting edge; optionally keep valid high.
  task automatic send(input int d, input logic [3:0] w, input logic hold);
    drive(d, w, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) drive(d, w, 1'b0);
  endtask

  // Called just after the accepting edge: checks each line bit, then the done cycle.
  task automatic expect_frame(input int d, input string tag, input string bits);
    logic [3:0] o;
    for (int k = 0; k < bits.len(); k++) begin
      @(negedge clk);
      o = obs(d);
      check($sformatf("%s_so%0d", tag, k), {31'd0, o[2]}, {31'd0, bits.getc(k) == "1"});
      check($sformatf("%s_st%0d", tag, k), {28'd0, o[3], 1'b0, o[1], o[0]}, 32'h2);
    end
    @(negedge clk);
    o = obs(d);
    check($sformatf("%s_done", tag), {28'd0, o}, 32'hD);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(0, 4'h0, 1'b1);
    drive(1, 4'h0, 1'b1);
    drive(2, 4'h0, 1'b1);

    // Reset held with valid asserted and clocks running: idle outputs, no frame.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_a", {28'd0, obs(0)}, 32'hC);
      check("rst_b", {28'd0, obs(1)}, 32'hC);
      check("rst_c", {28'd0, obs(2)}, 32'hC);
    end
    drive(0, 4'h0, 1'b0);
    drive(1, 4'h0, 1'b0);
    drive(2, 4'h0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_a", {28'd0, obs(0)}, 32'hC);
      check("post_rst_c", {28'd0, obs(2)}, 32'hC);
    end

    // LSB-first 1010.
    send(0, 4'b1010, 1'b0);
    expect_frame(0, "lsb", "001011");
    @(negedge clk);
    check("lsb_done_drop", {28'd0, obs(0)}, 32'hC);

    // MSB-first 1100.
    send(1, 4'b1100, 1'b0);
    expect_frame(1, "msb", "011001");

    // Stretched baud, 0001.
    send(2, 4'b0001, 1'b0);
    expect_frame(2, "baud", "000111000000000111");
    @(negedge clk);
    check("baud_idle", {28'd0, obs(2)}, 32'hC);

    // Capture isolation and back-to-back acceptance in the done cycle.
    send(0, 4'b1010, 1'b1);
    fork
      begin
        @(posedge clk);
        #1;
        a_if.pi = 4'b0101;
      end
    join_none
    expect_frame(0, "b2b1", "001011");
    @(posedge clk);
    #1;
    a_if.load_valid = 1'b0;
    expect_frame(0, "b2b2", "010101");

    // Reset during data bit 2 of an all-zero word.
    @(negedge clk);
    send(0, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("mid_so_before", {31'd0, a_if.so}, 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_now", {28'd0, obs(0)}, 32'hC);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("mid_quiet%0d", i), {28'd0, obs(0)}, 32'hC);
    end
    send(0, 4'b1111, 1'b0);
    expect_frame(0, "after_rst", "011111");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
